// File: rtl/inst_encoder_loader_if.sv
// inst_encoder_loader_if: field-bundle input handshake and instruction-memory write port
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       add_imm;
    logic [25:0]       j_add;
    logic              load_addr;
    logic [ADDR_W-1:0] start_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              busy;
    logic [15:0]       words_written;
    logic              err;

    modport master (
        output in_valid, fmt, op, funct, rs, rt, rd, shamt, add_imm, j_add,
        output load_addr, start_addr, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, words_written, err
    );

    modport slave (
        input  in_valid, fmt, op, funct, rs, rt, rd, shamt, add_imm, j_add,
        input  load_addr, start_addr, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, words_written, err
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs decoded fields into instruction words and streams them into instruction memory through a small FIFO
module inst_encoder_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    inst_encoder_loader_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_fifo [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;
    logic [ADDR_W-1:0] r_wptr;
    logic [15:0]       r_words;
    logic              r_err;
    logic [31:0]       w_word;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_illegal;
    logic              w_push;
    logic              w_pop;
    logic              w_mem_we;
    logic              w_load_ok;
    logic              w_load_bad;

    assign w_full     = r_count == (PW+1)'(DEPTH);
    assign w_empty    = r_count == '0;
    assign w_accept   = bus.in_valid && !w_full;
    assign w_illegal  = w_accept && bus.fmt == 2'b11;
    assign w_push     = w_accept && bus.fmt != 2'b11;
    assign w_mem_we   = r_state == S_WRITE;
    assign w_pop      = w_mem_we && bus.mem_ack;
    assign w_load_ok  = bus.load_addr && r_state == S_IDLE && w_empty && !w_push;
    assign w_load_bad = bus.load_addr && !w_load_ok;

    // Field packing in the decoder's layout; fmt 11 falls through to J but is never pushed
    always_comb begin
        w_word = bus.fmt == 2'b00 ? {bus.op, bus.rd, bus.rt, bus.rs, bus.shamt, bus.funct} :
                 bus.fmt == 2'b01 ? {bus.op, bus.rd, bus.rt, bus.add_imm} :
                                    {bus.op, bus.j_add};
    end

    // FIFO storage needs no reset: occupancy tracking decides what is valid
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_tail] <= w_word;
    end

    // FIFO pointers and occupancy; push and pop together leave occupancy unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + 1'b1;
            if (w_pop)
                r_head <= r_head + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Enter WRITE on the accepting edge so the first word is presented one cycle after acceptance
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE)
            w_state_nxt = (!w_empty || w_push) ? S_WRITE : S_IDLE;
        else
            w_state_nxt = (w_pop && r_count == (PW+1)'(1) && !w_push) ? S_IDLE : S_WRITE;
    end

    // Write pointer, completed-write counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_load_ok)
                r_wptr <= bus.start_addr;
            else if (w_pop)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_words <= r_words + 16'd1;
            if (w_illegal || w_load_bad)
                r_err <= 1'b1;
        end
    end

    assign bus.in_ready      = !w_full;
    assign bus.mem_we        = w_mem_we;
    assign bus.mem_addr      = r_wptr;
    assign bus.mem_wdata     = w_mem_we ? r_fifo[r_head] : 32'd0;
    assign bus.busy          = !w_empty || w_mem_we;
    assign bus.words_written = r_words;
    assign bus.err           = r_err;
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: vector table, directed corner cases and random traffic against a queue-based model
module tb_inst_encoder_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [4:0]  rs;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] jadd;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    vec_t tv [7];

    logic [31:0]       m_q [$];
    logic [ADDR_W-1:0] m_addr = '0;
    logic [15:0]       m_ww = '0;
    logic              m_err = 1'b0;

    inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();
    inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input vec_t v);
        longint w;
        w = longint'(v.op) * 67108864;
        if (v.fmt == 2'd2)
            w += longint'(v.jadd);
        else if (v.fmt == 2'd1)
            w += longint'(v.rd) * 2097152 + longint'(v.rt) * 65536 + longint'(v.imm);
        else
            w += longint'(v.rd) * 2097152 + longint'(v.rt) * 65536 + longint'(v.rs) * 2048
                 + longint'(v.shamt) * 64 + longint'(v.funct);
        return w[31:0];
    endfunction

    task automatic set_vec(input vec_t v);
        bus.fmt = v.fmt; bus.op = v.op; bus.rd = v.rd; bus.rt = v.rt; bus.rs = v.rs;
        bus.shamt = v.shamt; bus.funct = v.funct; bus.add_imm = v.imm; bus.j_add = v.jadd;
    endtask

    task automatic idle_inputs();
        vec_t z;
        z = '{2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0};
        set_vec(z);
        bus.in_valid = 1'b0;
        bus.load_addr = 1'b0;
        bus.start_addr = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic push(input vec_t v);
        int k;
        set_vec(v);
        bus.in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stuck at 0 for %0d cycles", k);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model: a queue of pending words, write address, counter and sticky error
    always @(negedge clk) begin
        vec_t v;
        logic pushing;
        if (!rst_n) begin
            m_q.delete();
            m_addr = '0;
            m_ww = '0;
            m_err = 1'b0;
        end else begin
            check("mem_we", 32'(bus.mem_we), 32'(m_q.size() != 0));
            check("in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
            check("busy", 32'(bus.busy), 32'(m_q.size() != 0));
            check("words_written", 32'(bus.words_written), 32'(m_ww));
            check("err", 32'(bus.err), 32'(m_err));
            if (m_q.size() != 0) begin
                check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
                check("mem_wdata", bus.mem_wdata, m_q[0]);
            end
            v = '{bus.fmt, bus.op, bus.rd, bus.rt, bus.rs, bus.shamt, bus.funct, bus.add_imm, bus.j_add, 32'd0};
            pushing = bus.in_valid && m_q.size() < DEPTH && bus.fmt != 2'd3;
            if (bus.in_valid && m_q.size() < DEPTH && bus.fmt == 2'd3)
                m_err = 1'b1;
            if (bus.load_addr) begin
                if (m_q.size() == 0 && !pushing)
                    m_addr = bus.start_addr;
                else
                    m_err = 1'b1;
            end
            if (bus.mem_ack && m_q.size() != 0) begin
                void'(m_q.pop_front());
                m_addr = m_addr + 1'b1;
                m_ww = m_ww + 16'd1;
            end
            if (pushing)
                m_q.push_back(ref_word(v));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tv[0] = '{2'd0, 6'h00, 5'd3,  5'd5,  5'd7,  5'd0,  6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h00653820};
        tv[1] = '{2'd1, 6'h08, 5'd2,  5'd1,  5'd31, 5'd31, 6'h3F, 16'h1234, 26'h3FFFFFF, 32'h20411234};
        tv[2] = '{2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000100, 32'h08000100};
        tv[3] = '{2'd0, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 26'h0,       32'hFFFFFFFF};
        tv[4] = '{2'd1, 6'h23, 5'd31, 5'd0,  5'd0,  5'd0,  6'h00, 16'h8000, 26'h0,       32'h8FE08000};
        tv[5] = '{2'd2, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
        tv[6] = '{2'd0, 6'h00, 5'd0,  5'd0,  5'd0,  5'd16, 6'h01, 16'hABCD, 26'h0,       32'h00000401};
        idle_inputs();
        bus.mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_words", 32'(bus.words_written), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table: one word at a time, latency and packing
        bus.mem_ack = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            push(tv[i]);
            @(negedge clk);
            check("tbl_mem_we", 32'(bus.mem_we), 32'd1);
            check("tbl_mem_addr", 32'(bus.mem_addr), 32'(i));
            check("tbl_mem_wdata", bus.mem_wdata, tv[i].exp);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("tbl_words", 32'(bus.words_written), 32'd7);

        // Back-to-back I then J
        do_reset();
        bus.mem_ack = 1'b1;
        set_vec(tv[1]);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 set_vec(tv[2]);
        @(negedge clk);
        check("stream0_addr", 32'(bus.mem_addr), 32'd0);
        check("stream0_data", bus.mem_wdata, 32'h20411234);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("stream1_we", 32'(bus.mem_we), 32'd1);
        check("stream1_addr", 32'(bus.mem_addr), 32'd1);
        check("stream1_data", bus.mem_wdata, 32'h08000100);

        // Backpressure: four fill the FIFO, fifth waits for the first ack
        do_reset();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++)
            push(tv[i]);
        set_vec(tv[4]);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_addr", 32'(bus.mem_addr), 32'd0);
            check("hold_data", bus.mem_wdata, tv[0].exp);
        end
        @(posedge clk);
        #1 bus.mem_ack = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0)
                check("full_until_ack", 32'(bus.in_ready), 32'd0);
            check("drain_addr", 32'(bus.mem_addr), 32'(j));
            check("drain_data", bus.mem_wdata, tv[j].exp);
            if (j == 1) begin
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("drain_words", 32'(bus.words_written), 32'd5);
        check("drain_busy", 32'(bus.busy), 32'd0);

        // Address load and wrap, then a rejected load while busy
        do_reset();
        bus.mem_ack = 1'b1;
        bus.load_addr = 1'b1;
        bus.start_addr = 10'h3FF;
        @(posedge clk);
        #1 bus.load_addr = 1'b0;
        push(tv[0]);
        @(negedge clk);
        check("load_addr_3ff", 32'(bus.mem_addr), 32'h3FF);
        @(posedge clk);
        #1;
        push(tv[1]);
        @(negedge clk);
        check("load_wrap_addr", 32'(bus.mem_addr), 32'h000);
        check("load_wrap_data", bus.mem_wdata, tv[1].exp);
        check("load_err_clear", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        push(tv[2]);
        bus.load_addr = 1'b1;
        bus.start_addr = 10'h055;
        @(posedge clk);
        #1 bus.load_addr = 1'b0;
        @(negedge clk);
        check("busy_load_err", 32'(bus.err), 32'd1);
        check("busy_load_addr", 32'(bus.mem_addr), 32'd1);
        @(posedge clk);
        #1 bus.mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Illegal format: consumed, nothing written, err sticks
        do_reset();
        bus.mem_ack = 1'b1;
        v = tv[0];
        v.fmt = 2'd3;
        set_vec(v);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("ill_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ill_mem_we", 32'(bus.mem_we), 32'd0);
            check("ill_err", 32'(bus.err), 32'd1);
            check("ill_words", 32'(bus.words_written), 32'd0);
        end

        // Reset while three words wait for an ack
        do_reset();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            push(tv[i]);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_mem_we", 32'(bus.mem_we), 32'd0);
        check("rstw_busy", 32'(bus.busy), 32'd0);
        check("rstw_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        push(tv[3]);
        @(negedge clk);
        check("rstw_next_addr", 32'(bus.mem_addr), 32'd0);
        check("rstw_next_data", bus.mem_wdata, tv[3].exp);

        // Random traffic checked by the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            v.fmt = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
            v.op = 6'($urandom); v.rd = 5'($urandom); v.rt = 5'($urandom); v.rs = 5'($urandom);
            v.shamt = 5'($urandom); v.funct = 6'($urandom); v.imm = 16'($urandom); v.jadd = 26'($urandom);
            set_vec(v);
            bus.in_valid = ($urandom % 3) != 0;
            bus.mem_ack = ($urandom % 2) != 0;
            bus.load_addr = ($urandom % 20) == 0;
            bus.start_addr = ADDR_W'($urandom);
        end
        @(posedge clk);
        #1 idle_inputs();
        bus.mem_ack = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rand_drained", 32'(bus.busy), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
